// File: rtl/sr_debug_ctrl_if.sv
// rtl/sr_debug_ctrl_if.sv - command and dump-stream bundle between the debug bridge and sr_debug_ctrl
interface sr_debug_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_err;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, dump_ready,
    input  cmd_ready, cmd_err, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, dump_ready,
    output cmd_ready, cmd_err, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/sr_debug_ctrl.sv
// rtl/sr_debug_ctrl.sv - run-control, PC breakpoint and register-dump sequencer for sr_cpu
module sr_debug_ctrl #(
  parameter int RESET_HALTED = 1,
  parameter int STEP_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sr_debug_ctrl_if.slave        dbg,
  input  logic                  bp_en,
  input  logic [31:0]           bp_addr,
  output logic                  cpu_en,
  output logic [4:0]            regAddr,
  input  logic [31:0]           regData,
  output logic                  halted,
  output logic [31:0]           instret
);
  typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP, S_DUMP} state_t;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_HALT = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  state_t            state;
  logic [STEP_W-1:0] stepCnt;
  logic [4:0]        idx;
  logic              skipBp;
  logic [31:0]       pc;
  logic              bpHit;
  logic              cmdFire;
  logic              dumpFire;
  logic [STEP_W-1:0] stepArg;

  // The debug port doubles as the PC source: address 0 outside a dump reads the PC.
  assign regAddr  = (state == S_DUMP) ? idx : 5'd0;
  assign pc       = regData;
  assign bpHit    = bp_en && (pc == bp_addr) && !skipBp;
  assign cpu_en   = ((state == S_RUN) && !bpHit) || (state == S_STEP);
  assign halted   = (state == S_HALTED);
  assign stepArg  = dbg.cmd_arg[STEP_W-1:0];

  assign dbg.cmd_ready  = (state == S_RUN) || (state == S_HALTED);
  assign dbg.dump_valid = (state == S_DUMP);
  assign dbg.dump_idx   = idx;
  assign dbg.dump_data  = regData;

  assign cmdFire  = dbg.cmd_valid && dbg.cmd_ready;
  assign dumpFire = dbg.dump_valid && dbg.dump_ready;

  generate
    if (STEP_W < 32) begin : g_argHi
      logic unusedArgHi;
      assign unusedArgHi = ^dbg.cmd_arg[31:STEP_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= (RESET_HALTED != 0) ? S_HALTED : S_RUN;
      stepCnt     <= '0;
      idx         <= 5'd0;
      skipBp      <= 1'b0;
      instret     <= 32'd0;
      dbg.cmd_err <= 1'b0;
    end else begin
      dbg.cmd_err <= 1'b0;
      if (cpu_en) begin
        instret <= instret + 32'd1;
      end

      case (state)
        S_HALTED: begin
          if (cmdFire) begin
            case (dbg.cmd_op)
              OP_RUN: begin
                state  <= S_RUN;
                skipBp <= 1'b1;
              end
              OP_STEP: begin
                state   <= S_STEP;
                stepCnt <= (stepArg == '0) ? STEP_W'(1) : stepArg;
              end
              OP_DUMP: begin
                state <= S_DUMP;
                idx   <= 5'd0;
              end
              default: ;
            endcase
          end
        end

        S_RUN: begin
          // skipBp only covers the first cycle after resume, so a bp at the resume PC is stepped over once.
          skipBp <= 1'b0;
          if (bpHit || (cmdFire && dbg.cmd_op == OP_HALT)) begin
            state <= S_HALTED;
          end
          if (cmdFire && (dbg.cmd_op == OP_STEP || dbg.cmd_op == OP_DUMP)) begin
            dbg.cmd_err <= 1'b1;
          end
        end

        S_STEP: begin
          stepCnt <= stepCnt - STEP_W'(1);
          if (stepCnt == STEP_W'(1)) begin
            state <= S_HALTED;
          end
        end

        S_DUMP: begin
          if (dumpFire) begin
            if (idx == 5'd31) begin
              state <= S_HALTED;
              idx   <= 5'd0;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end

        default: state <= S_HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_debug_ctrl.sv
// tb/tb_sr_debug_ctrl.sv - self-checking bench for sr_debug_ctrl with a simple core PC/register model
module tb_sr_debug_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic        cpu_en;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        halted;
  logic [31:0] instret;

  sr_debug_ctrl_if dbg();

  int checks = 0;
  int failures = 0;

  logic [31:0] corePc;
  logic [31:0] coreRegs [32];
  logic [31:0] expRet = 32'd0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } dump_word_t;

  dump_word_t  dumpQ[$];
  logic [31:0] instretQ[$];

  sr_debug_ctrl #(.RESET_HALTED(1), .STEP_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .dbg     (dbg),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .cpu_en  (cpu_en),
    .regAddr (regAddr),
    .regData (regData),
    .halted  (halted),
    .instret (instret)
  );

  always #5 clk = ~clk;

  // Core model: one instruction per enabled cycle, PC advances by 4.
  always @(posedge clk) begin
    if (rst) corePc <= 32'd0;
    else if (cpu_en) corePc <= corePc + 32'd4;
  end

  assign regData = (regAddr == 5'd0) ? corePc : coreRegs[regAddr];

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
    dbg.cmd_valid = 1'b1;
    dbg.cmd_op    = op;
    dbg.cmd_arg   = arg;
    #1;
    checks++;
    if (dbg.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_at_issue op=%0d got=%b exp=1", op, dbg.cmd_ready);
    end
    next_cycle();
    dbg.cmd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dbg.cmd_valid = 1'b0;
    dbg.cmd_op = 2'd0;
    dbg.cmd_arg = 32'd0;
    dbg.dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expRet = 32'd0;
    #1;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted got=%b exp=1", halted); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
    checks++; if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if (dbg.dump_valid !== 1'b0) begin failures++; $display("FAIL reset_dump_valid got=%b exp=0", dbg.dump_valid); end
    checks++; if (dbg.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", dbg.cmd_ready); end
    checks++; if (dbg.cmd_err !== 1'b0) begin failures++; $display("FAIL reset_cmd_err got=%b exp=0", dbg.cmd_err); end
  endtask

  task automatic test_step(input logic [31:0] arg, input int n);
    int enCycles = 0;
    int notReady = 0;
    int guard = 0;
    logic [31:0] want;
    expRet = expRet + 32'(n);
    instretQ.push_back(expRet);
    send_cmd(2'd2, arg);
    while (!halted && guard < 100) begin
      if (cpu_en) enCycles++;
      if (!dbg.cmd_ready) notReady++;
      next_cycle();
      #1;
      guard++;
    end
    want = instretQ.pop_front();
    checks++; if (guard >= 100) begin failures++; $display("FAIL step_timeout arg=%h got=%0d exp<100", arg, guard); end
    checks++; if (enCycles != n) begin failures++; $display("FAIL step_cpu_en_cycles arg=%h got=%0d exp=%0d", arg, enCycles, n); end
    checks++; if (notReady != n) begin failures++; $display("FAIL step_cmd_ready_low arg=%h got=%0d exp=%0d", arg, notReady, n); end
    checks++; if (instret !== want) begin failures++; $display("FAIL step_instret arg=%h got=%0d exp=%0d", arg, instret, want); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL step_cpu_en_after arg=%h got=%b exp=0", arg, cpu_en); end
  endtask

  task automatic test_breakpoint;
    int enCycles = 0;
    int guard = 0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    expRet = 32'd0;
    bp_en = 1'b1;
    bp_addr = 32'h10;
    send_cmd(2'd0, 32'd0);
    while (!halted && guard < 50) begin
      if (cpu_en) enCycles++;
      next_cycle();
      #1;
      guard++;
    end
    expRet = expRet + 32'd4;
    checks++; if (enCycles != 4) begin failures++; $display("FAIL bp_cycles_before_halt got=%0d exp=4", enCycles); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL bp_halted got=%b exp=1", halted); end
    checks++; if (corePc !== 32'h10) begin failures++; $display("FAIL bp_pc_at_halt got=%h exp=00000010", corePc); end
    checks++; if (instret !== expRet) begin failures++; $display("FAIL bp_instret got=%0d exp=%0d", instret, expRet); end

    // Resume from the breakpoint PC, then an illegal DUMP while running, then HALT.
    send_cmd(2'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (halted !== 1'b0 || cpu_en !== 1'b1) begin failures++; $display("FAIL bp_resume_run cyc=%0d halted=%b cpu_en=%b exp halted=0 cpu_en=1", i, halted, cpu_en); end
      next_cycle();
      #1;
    end
    send_cmd(2'd3, 32'd0);
    checks++; if (dbg.cmd_err !== 1'b1) begin failures++; $display("FAIL run_dump_cmd_err got=%b exp=1", dbg.cmd_err); end
    checks++; if (dbg.dump_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL run_dump_state dump_valid=%b halted=%b exp 0 0", dbg.dump_valid, halted); end
    next_cycle();
    #1;
    checks++; if (dbg.cmd_err !== 1'b0) begin failures++; $display("FAIL run_dump_cmd_err_width got=%b exp=0", dbg.cmd_err); end
    dbg.cmd_valid = 1'b1;
    dbg.cmd_op = 2'd1;
    #1;
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL halt_cycle_cpu_en got=%b exp=1", cpu_en); end
    next_cycle();
    dbg.cmd_valid = 1'b0;
    #1;
    expRet = expRet + 32'd9;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_cmd_halted got=%b exp=1", halted); end
    checks++; if (corePc !== 32'h34) begin failures++; $display("FAIL resume_pc got=%h exp=00000034", corePc); end
    checks++; if (instret !== expRet) begin failures++; $display("FAIL resume_instret got=%0d exp=%0d", instret, expRet); end
    bp_en = 1'b0;
  endtask

  task automatic test_dump;
    int guard = 0;
    logic tog = 1'b0;
    dump_word_t w;
    for (int i = 0; i < 32; i++) begin
      w.idx = 5'(i);
      w.data = (i == 0) ? 32'h34 : coreRegs[i];
      dumpQ.push_back(w);
    end
    dbg.dump_ready = 1'b0;
    send_cmd(2'd3, 32'd0);
    while (dumpQ.size() > 0 && guard < 200) begin
      dbg.dump_ready = tog;
      #1;
      checks++; if (dbg.dump_valid !== 1'b1 || cpu_en !== 1'b0) begin failures++; $display("FAIL dump_valid_cpu_en valid=%b cpu_en=%b exp 1 0", dbg.dump_valid, cpu_en); end
      checks++; if (dbg.dump_idx !== dumpQ[0].idx) begin failures++; $display("FAIL dump_idx got=%0d exp=%0d", dbg.dump_idx, dumpQ[0].idx); end
      checks++; if (dbg.dump_data !== dumpQ[0].data) begin failures++; $display("FAIL dump_data idx=%0d got=%h exp=%h", dumpQ[0].idx, dbg.dump_data, dumpQ[0].data); end
      if (tog) void'(dumpQ.pop_front());
      tog = ~tog;
      next_cycle();
      guard++;
    end
    dbg.dump_ready = 1'b0;
    #1;
    checks++; if (guard >= 200) begin failures++; $display("FAIL dump_timeout got=%0d exp<200", guard); end
    checks++; if (halted !== 1'b1 || dbg.dump_valid !== 1'b0) begin failures++; $display("FAIL dump_end halted=%b dump_valid=%b exp 1 0", halted, dbg.dump_valid); end
    checks++; if (instret !== expRet) begin failures++; $display("FAIL dump_instret got=%0d exp=%0d", instret, expRet); end
  endtask

  task automatic test_reset_in_dump;
    int guard = 0;
    dbg.dump_ready = 1'b1;
    send_cmd(2'd3, 32'd0);
    while (dbg.dump_idx !== 5'd12 && guard < 50) begin
      next_cycle();
      #1;
      guard++;
    end
    checks++; if (dbg.dump_idx !== 5'd12) begin failures++; $display("FAIL rst_dump_reach_idx got=%0d exp=12", dbg.dump_idx); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    expRet = 32'd0;
    #1;
    checks++; if (dbg.dump_valid !== 1'b0) begin failures++; $display("FAIL rst_dump_valid got=%b exp=0", dbg.dump_valid); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rst_dump_halted got=%b exp=1", halted); end
    checks++; if (instret !== expRet) begin failures++; $display("FAIL rst_dump_instret got=%0d exp=0", instret); end
    dbg.dump_ready = 1'b0;
    send_cmd(2'd3, 32'd0);
    checks++; if (dbg.dump_valid !== 1'b1 || dbg.dump_idx !== 5'd0) begin failures++; $display("FAIL rst_dump_restart valid=%b idx=%0d exp 1 0", dbg.dump_valid, dbg.dump_idx); end
    checks++; if (dbg.dump_data !== 32'd0) begin failures++; $display("FAIL rst_dump_word0 got=%h exp=00000000", dbg.dump_data); end
    dbg.dump_ready = 1'b1;
    guard = 0;
    while (!halted && guard < 50) begin
      next_cycle();
      #1;
      guard++;
    end
    dbg.dump_ready = 1'b0;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rst_dump_drain got=%b exp=1", halted); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) coreRegs[i] = $urandom;
    test_reset();
    test_step(32'd3, 3);
    test_step(32'd0, 1);
    test_step(32'h0001_0002, 2);
    test_breakpoint();
    test_dump();
    test_reset_in_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
